// File: rtl/prog_loader_if.sv
// ----------------------------------------------------------------------------
// prog_loader_if
//   Bundles the byte-stream input and the ROM-write / status outputs of the
//   program loader.
//
//   Signals:
//     rx_valid  1   one-cycle strobe, rx_data valid this cycle (no backpressure)
//     rx_data   8   received byte
//     wr_en     1   one-cycle instruction ROM write strobe
//     wr_addr   8   ROM word address
//     wr_data   16  instruction word {hi, lo}
//     start     1   one-cycle launch pulse after a good frame
//     busy      1   loader is inside a frame
//     done      1   sticky, last frame loaded correctly
//     err       1   sticky, last frame failed
//     word_cnt  8   words written in the current or last frame
//
//   Modports:
//     master  byte source / status consumer (UART side, testbench)
//     slave   the loader itself
// ----------------------------------------------------------------------------
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  word_cnt;

  modport master (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, start, busy, done, err, word_cnt
  );

  modport slave (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, start, busy, done, err, word_cnt
  );
endinterface

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
//   Frames a UART byte stream  HEADER, LEN, LEN x {hi, lo}, CSUM  into 16-bit
//   instruction words, writes them to the instruction ROM at addresses
//   0..LEN-1 and pulses start once the checksum (mod-256 sum of all data
//   bytes) matches.
//
//   Parameters:
//     HEADER   frame start byte
//     TIMEOUT  idle cycles allowed between bytes inside a frame (2..65535)
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   prog_loader_if.slave (byte input, ROM write port, status)
//
//   Build option:
//     PROG_LOADER_TIMEOUT_EN  when defined, an idle counter aborts a frame
//                             (err set, no start) after TIMEOUT cycles
//                             without a byte. Undefined: frames wait forever.
//
//   All outputs are registered. The ROM samples on the falling clock edge,
//   so wr_addr/wr_data are stable for half a cycle before it writes.
// ----------------------------------------------------------------------------
module prog_loader #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("prog_loader: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CSUM} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_len, r_hi, r_sum, r_word_cnt;
  logic [7:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_en, r_start, r_busy, r_done, r_err;

  logic        w_timeout;
  logic        w_clear, w_len_ld, w_hi_ld, w_wr, w_start, w_done_set, w_err_set;

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [15:0] r_idle;

  // Counts edges without a byte while inside a frame. Timeout wins over a
  // byte arriving on the same edge, so that byte is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_idle <= 16'd0;
    else if (r_state == S_IDLE || bus.rx_valid || w_timeout)
      r_idle <= 16'd0;
    else
      r_idle <= r_idle + 16'd1;
  end

  assign w_timeout = (r_state != S_IDLE) && (r_idle == 16'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this purely combinational;
  // a path that leaves w_state_nxt unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (bus.rx_valid) begin
      case (r_state)
        S_IDLE:  if (bus.rx_data == HEADER) w_state_nxt = S_LEN;
        S_LEN:   w_state_nxt = (bus.rx_data == 8'd0) ? S_IDLE : S_HI;
        S_HI:    w_state_nxt = S_LO;
        S_LO:    w_state_nxt = (8'(r_word_cnt + 8'd1) == r_len) ? S_CSUM : S_HI;
        S_CSUM:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / datapath action decode; the actions are registered below.
  always_comb begin
    w_clear    = 1'b0;
    w_len_ld   = 1'b0;
    w_hi_ld    = 1'b0;
    w_wr       = 1'b0;
    w_start    = 1'b0;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    if (w_timeout) begin
      w_err_set = 1'b1;
    end else if (bus.rx_valid) begin
      case (r_state)
        S_IDLE: w_clear = (bus.rx_data == HEADER);
        S_LEN: begin
          w_err_set = (bus.rx_data == 8'd0);
          w_len_ld  = (bus.rx_data != 8'd0);
        end
        S_HI:   w_hi_ld = 1'b1;
        S_LO:   w_wr    = 1'b1;
        S_CSUM: begin
          w_start    = (bus.rx_data == r_sum);
          w_done_set = (bus.rx_data == r_sum);
          w_err_set  = (bus.rx_data != r_sum);
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= 8'd0;
      r_hi       <= 8'd0;
      r_sum      <= 8'd0;
      r_word_cnt <= 8'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 16'd0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= w_wr;
      r_start <= w_start;
      r_busy  <= (w_state_nxt != S_IDLE);

      if (w_clear) begin
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_word_cnt <= 8'd0;
        r_sum      <= 8'd0;
      end
      if (w_done_set) r_done <= 1'b1;
      if (w_err_set)  r_err  <= 1'b1;
      if (w_len_ld)   r_len  <= bus.rx_data;

      if (w_hi_ld) begin
        r_hi  <= bus.rx_data;
        r_sum <= r_sum + bus.rx_data;
      end

      // Address is the count before this word; LEN caps it at 254.
      if (w_wr) begin
        r_wr_addr  <= r_word_cnt;
        r_wr_data  <= {r_hi, bus.rx_data};
        r_sum      <= r_sum + bus.rx_data;
        r_word_cnt <= r_word_cnt + 8'd1;
      end
    end
  end

  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.start    = r_start;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.word_cnt = r_word_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_prog_loader
//   Drives directed and random frames into prog_loader and compares the ROM
//   writes and status outputs against expectations derived at frame level
//   (word list, arithmetic checksum). Honours PROG_LOADER_TIMEOUT_EN for the
//   stalled-frame scenario (TIMEOUT = 10).
// ----------------------------------------------------------------------------
module tb_prog_loader;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  prog_loader_if bus();

  prog_loader #(.HEADER(HDR), .TIMEOUT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM model and write/start monitor, sampled on the falling edge.
  logic [15:0] rom [256];
  logic [23:0] got_writes [$];
  int          start_cnt = 0;
  logic [15:0] exp_words [$];

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      got_writes.push_back({bus.wr_addr, bus.wr_data});
      rom[bus.wr_addr] <= bus.wr_data;
    end
    if (bus.start === 1'b1) start_cnt <= start_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},    bus.wr_en,    0);
    check({tag, "_wr_addr"},  bus.wr_addr,  0);
    check({tag, "_wr_data"},  bus.wr_data,  0);
    check({tag, "_start"},    bus.start,    0);
    check({tag, "_busy"},     bus.busy,     0);
    check({tag, "_done"},     bus.done,     0);
    check({tag, "_err"},      bus.err,      0);
    check({tag, "_word_cnt"}, bus.word_cnt, 0);
  endtask

  // Entered at the falling edge right after the CSUM byte was taken.
  task automatic check_frame(input string tag, input int wbase, input int sbase, input bit good);
    #1;
    check({tag, "_start"},    bus.start,    good);
    check({tag, "_busy"},     bus.busy,     0);
    check({tag, "_done"},     bus.done,     good);
    check({tag, "_err"},      bus.err,      !good);
    check({tag, "_word_cnt"}, bus.word_cnt, exp_words.size());
    @(negedge clk);
    #1;
    check({tag, "_start_width"}, bus.start, 0);
    check({tag, "_start_cnt"},   start_cnt - sbase, good);
    check({tag, "_n_writes"},    got_writes.size() - wbase, exp_words.size());
    foreach (exp_words[i]) begin
      if (wbase + i < got_writes.size())
        check($sformatf("%s_wr%0d", tag, i), got_writes[wbase + i], {i[7:0], exp_words[i]});
      check($sformatf("%s_rom%0d", tag, i), rom[i], exp_words[i]);
    end
  endtask

  // Sends exp_words as a frame; checksum is the arithmetic byte sum,
  // deliberately off by one when good == 0.
  task automatic send_frame(input bit good, input int gap_max);
    logic [7:0] sum;
    sum = 8'd0;
    send(HDR);
    send(8'(exp_words.size()));
    foreach (exp_words[i]) begin
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
      send(exp_words[i][15:8]);
      send(exp_words[i][7:0]);
      sum = sum + exp_words[i][15:8] + exp_words[i][7:0];
    end
    send(good ? sum : 8'(sum + 8'd1));
  endtask

  task automatic random_frame(input string tag, input int n, input bit good, input int gap_max);
    int wbase, sbase;
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
    wbase = got_writes.size();
    sbase = start_cnt;
    send_frame(good, gap_max);
    check_frame(tag, wbase, sbase, good);
  endtask

  initial begin
    int wbase, sbase;
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(2);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Good frame from known bytes.
    exp_words = '{16'h1234, 16'h5678};
    wbase = got_writes.size(); sbase = start_cnt;
    send(HDR); send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h14);
    check_frame("good", wbase, sbase, 1'b1);

    // Same frame, corrupted checksum: writes stay, no start.
    wbase = got_writes.size(); sbase = start_cnt;
    send(HDR); send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h15);
    check_frame("badsum", wbase, sbase, 1'b0);

    // Zero length.
    wbase = got_writes.size(); sbase = start_cnt;
    send(HDR); send(8'h00);
    #1;
    check("zero_err",      bus.err,      1);
    check("zero_busy",     bus.busy,     0);
    check("zero_done",     bus.done,     0);
    check("zero_word_cnt", bus.word_cnt, 0);
    idle(2);
    check("zero_n_writes", got_writes.size() - wbase, 0);
    check("zero_start",    start_cnt - sbase, 0);
    random_frame("after_zero", 3, 1'b1, 0);

    // Noise before header, header value used as data inside the frame.
    send(8'h00); send(8'hFF);
    #1;
    check("noise_busy", bus.busy, 0);
    @(negedge clk);
    exp_words = '{16'hA5A5};
    wbase = got_writes.size(); sbase = start_cnt;
    send(HDR); send(8'h01); send(HDR); send(HDR); send(8'h4A);
    check_frame("embedded_hdr", wbase, sbase, 1'b1);

    // Reset mid-frame, then a fresh frame loads from address 0.
    send(HDR); send(8'h03); send(8'h11);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    random_frame("post_reset", 3, 1'b1, 0);

    // Stalled frame.
    sbase = start_cnt;
    send(HDR); send(8'h02); send(8'h12);
`ifdef PROG_LOADER_TIMEOUT_EN
    idle(9);
    #1;
    check("to_busy_before", bus.busy, 1);
    check("to_err_before",  bus.err,  0);
    @(negedge clk);
    #1;
    check("to_err",   bus.err,  1);
    check("to_busy",  bus.busy, 0);
    check("to_done",  bus.done, 0);
    check("to_start", start_cnt - sbase, 0);
`else
    idle(20);
    #1;
    check("stall_busy", bus.busy, 1);
    check("stall_err",  bus.err,  0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full-length frame back to back: last address 254, count 255.
    random_frame("len255", 255, 1'b1, 0);

    // Random frames with random gaps and random checksum corruption.
    for (int k = 0; k < 6; k++)
      random_frame($sformatf("rand%0d", k), $urandom_range(6, 1), 1'($urandom_range(1, 0)), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
